// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: default parameter
// values, the sequencer state encoding and a word-alignment helper.
package pc_pkg;

   // Default PC loaded on reset and default sequential step in bytes.
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_PC_STEP  = 32'd4;

   // Sequencer states. REDIRECT is the single bubble cycle after a taken
   // jump or branch; HALTED is left only through reset.
   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_REDIRECT = 2'd1,
      ST_HALTED   = 2'd2
   } pcState_t;

   // Force a byte address onto a word boundary.
   function automatic logic [31:0] alignWord(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

   // True when a byte address is not word aligned.
   function automatic logic isMisaligned(input logic [31:0] addr);
      return |addr[1:0];
   endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection. Applies the per-cycle priority
// halt > jump > branch > stall > sequential while the sequencer is running,
// aligns redirect targets to a word boundary and flags targets that were
// not aligned.
module pc_next_mux
   import pc_pkg::*;
(
   input  logic        runActive,
   input  logic        halt,
   input  logic        stall,
   input  logic        jumpValid,
   input  logic [31:0] jumpAddress,
   input  logic        branchValid,
   input  logic [31:0] branchOffset,
   input  logic [31:0] pcCurrent,
   input  logic [31:0] pcPlus4,
   output logic [31:0] pcNext,
   output logic        redirectTake,
   output logic        targetMisaligned
);

   logic [31:0] branchTarget;
   logic [31:0] rawTarget;

   // Branch target is relative to the sequential address; wraps mod 2^32.
   assign branchTarget = pcPlus4 + branchOffset;

   // A simultaneous jump always wins over a branch.
   assign rawTarget = jumpValid ? jumpAddress : branchTarget;

   // Select the next PC; outside RUN, or when halting, the PC holds.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      pcNext           = pcCurrent;
      redirectTake     = 1'b0;
      targetMisaligned = 1'b0;
      if (runActive && !halt) begin
         if (jumpValid || branchValid) begin
            redirectTake     = 1'b1;
            pcNext           = alignWord(rawTarget);
            targetMisaligned = isMisaligned(rawTarget);
         end else if (!stall) begin
            pcNext = pcPlus4;
         end
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter owner for the MIPS datapath. Holds the PC, the
// RUN/REDIRECT/HALTED state and the registered fetch_valid, flush, halted
// and misalign_err outputs. Next-PC selection lives in pc_next_mux.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        jump_valid,
   input  logic [31:0] jump_address,
   input  logic        branch_valid,
   input  logic [31:0] branch_offset,
   input  logic        halt,
   output logic [31:0] program_counter,
   output logic [31:0] pc_plus4,
   output logic        fetch_valid,
   output logic        flush,
   output logic        halted,
   output logic        misalign_err
);

   pcState_t    state;
   pcState_t    stateNext;
   logic [31:0] pcReg;
   logic [31:0] pcNext;
   logic        redirectTake;
   logic        targetMisaligned;
   logic        fetchValidReg;
   logic        flushReg;
   logic        haltedReg;
   logic        misalignReg;
   logic        fetchValidNext;
   logic        flushNext;
   logic        haltedNext;

   // Sequential address; wraps from 0xFFFF_FFFC to 0x0000_0000.
   assign pc_plus4 = pcReg + PC_STEP;

   pc_next_mux uNextMux (
      .runActive        (state == ST_RUN),
      .halt             (halt),
      .stall            (stall),
      .jumpValid        (jump_valid),
      .jumpAddress      (jump_address),
      .branchValid      (branch_valid),
      .branchOffset     (branch_offset),
      .pcCurrent        (pcReg),
      .pcPlus4          (pc_plus4),
      .pcNext           (pcNext),
      .redirectTake     (redirectTake),
      .targetMisaligned (targetMisaligned)
   );

   // Next-state decode and the values the output flops load from it.
   always_comb begin
      stateNext = state;
      unique case (state)
         ST_RUN: begin
            if (halt) begin
               stateNext = ST_HALTED;
            end else if (redirectTake) begin
               stateNext = ST_REDIRECT;
            end
         end
         // The instruction in flight is flushed, so its halt is ignored too.
         ST_REDIRECT: stateNext = ST_RUN;
         ST_HALTED:   stateNext = ST_HALTED;
         default:     stateNext = ST_RUN;
      endcase
      fetchValidNext = (stateNext == ST_RUN);
      flushNext      = (stateNext == ST_REDIRECT);
      haltedNext     = (stateNext == ST_HALTED);
   end

   // State register; reset wins over every other input.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         state <= ST_RUN;
      end else begin
         state <= stateNext;
      end
   end

   // PC and registered outputs; misalign_err is sticky until reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         pcReg         <= RESET_PC;
         fetchValidReg <= 1'b1;
         flushReg      <= 1'b0;
         haltedReg     <= 1'b0;
         misalignReg   <= 1'b0;
      end else begin
         pcReg         <= pcNext;
         fetchValidReg <= fetchValidNext;
         flushReg      <= flushNext;
         haltedReg     <= haltedNext;
         misalignReg   <= misalignReg | targetMisaligned;
      end
   end

   assign program_counter = pcReg;
   assign fetch_valid     = fetchValidReg;
   assign flush           = flushReg;
   assign halted          = haltedReg;
   assign misalign_err    = misalignReg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed steps from the test plan
// followed by randomized cycles, all compared against a behavioural model.
module tb_pc_sequencer;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        jump_valid;
   logic [31:0] jump_address;
   logic        branch_valid;
   logic [31:0] branch_offset;
   logic        halt;
   logic [31:0] program_counter;
   logic [31:0] pc_plus4;
   logic        fetch_valid;
   logic        flush;
   logic        halted;
   logic        misalign_err;

   int testCount = 0;
   int failCount = 0;

   // Behavioural model: the PC, plus flags for "in the bubble after a
   // redirect", "halted" and the sticky misalignment error.
   logic [31:0] mPc;
   bit          mBubble;
   bit          mHalted;
   bit          mMisalign;

   pc_sequencer dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .jump_valid      (jump_valid),
      .jump_address    (jump_address),
      .branch_valid    (branch_valid),
      .branch_offset   (branch_offset),
      .halt            (halt),
      .program_counter (program_counter),
      .pc_plus4        (pc_plus4),
      .fetch_valid     (fetch_valid),
      .flush           (flush),
      .halted          (halted),
      .misalign_err    (misalign_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Apply the sequencer rules to the model for the inputs now driven.
   task automatic modelStep();
      logic [31:0] target;
      if (reset) begin
         mPc = 32'h0; mBubble = 0; mHalted = 0; mMisalign = 0;
      end else if (mHalted) begin
         // frozen until reset
      end else if (mBubble) begin
         mBubble = 0;
      end else if (halt) begin
         mHalted = 1;
      end else if (jump_valid || branch_valid) begin
         target = jump_valid ? jump_address : (mPc + 32'd4 + branch_offset);
         if (target % 4 != 0) mMisalign = 1;
         mPc = target & ~32'd3;
         mBubble = 1;
      end else if (!stall) begin
         mPc = mPc + 32'd4;
      end
   endtask

   // Advance one clock and compare every output with the model.
   task automatic cycle();
      modelStep();
      @(posedge clk);
      #1;
      check("program_counter", program_counter, mPc);
      check("pc_plus4", pc_plus4, mPc + 32'd4);
      check("fetch_valid", {31'b0, fetch_valid}, {31'b0, !mHalted && !mBubble});
      check("flush", {31'b0, flush}, {31'b0, mBubble});
      check("halted", {31'b0, halted}, {31'b0, mHalted});
      check("misalign_err", {31'b0, misalign_err}, {31'b0, mMisalign});
   endtask

   task automatic clearInputs();
      reset = 0; stall = 0; jump_valid = 0; branch_valid = 0; halt = 0;
      jump_address = 32'h0; branch_offset = 32'h0;
   endtask

   task automatic doReset();
      reset = 1;
      cycle();
      reset = 0;
   endtask

   // Jump to addr and ride out the bubble so the PC sits at addr in RUN.
   task automatic jumpTo(input logic [31:0] addr);
      jump_valid = 1; jump_address = addr;
      cycle();
      jump_valid = 0;
      cycle();
   endtask

   initial begin
      logic [15:0] imm;
      clearInputs();
      reset = 1;
      mPc = 32'h0; mBubble = 0; mHalted = 0; mMisalign = 0;

      // Reset then three idle cycles.
      doReset();
      check("reset pc", program_counter, 32'h0);
      check("reset fetch_valid", {31'b0, fetch_valid}, 32'd1);
      check("reset flush", {31'b0, flush}, 32'd0);
      cycle(); check("idle pc 1", program_counter, 32'h4);
      cycle(); check("idle pc 2", program_counter, 32'h8);
      cycle(); check("idle pc 3", program_counter, 32'hC);

      // Jump from 0x0040_0010 to 0x0040_0100.
      jumpTo(32'h0040_0010);
      check("at jump source", program_counter, 32'h0040_0010);
      jump_valid = 1; jump_address = 32'h0040_0100;
      cycle();
      check("jump target", program_counter, 32'h0040_0100);
      check("jump flush", {31'b0, flush}, 32'd1);
      check("jump bubble fetch", {31'b0, fetch_valid}, 32'd0);
      jump_valid = 0;
      cycle();
      check("post-jump fetch", {31'b0, fetch_valid}, 32'd1);
      check("post-jump pc held", program_counter, 32'h0040_0100);
      cycle();
      check("post-jump seq", program_counter, 32'h0040_0104);

      // Backward branch from 0x20 with offset -16.
      jumpTo(32'h0000_0020);
      branch_valid = 1; branch_offset = 32'hFFFF_FFF0;
      cycle();
      check("branch target", program_counter, 32'h0000_0014);
      check("branch flush", {31'b0, flush}, 32'd1);
      branch_valid = 0;
      cycle();
      cycle();
      check("post-branch seq", program_counter, 32'h0000_0018);

      // Jump + branch + stall together at 0x8; jump wins. Held inputs
      // during the bubble must be ignored.
      doReset(); cycle(); cycle();
      check("at 0x8", program_counter, 32'h8);
      jump_valid = 1; branch_valid = 1; stall = 1;
      jump_address = 32'h200; branch_offset = 32'h40;
      cycle();
      check("jump beats branch", program_counter, 32'h200);
      jump_address = 32'h300; halt = 1;
      cycle();
      check("bubble ignores inputs", program_counter, 32'h200);
      check("bubble ignores halt", {31'b0, halted}, 32'd0);
      clearInputs();
      stall = 1;
      cycle();
      check("stall holds", program_counter, 32'h200);
      check("stall keeps fetch", {31'b0, fetch_valid}, 32'd1);
      stall = 0;

      // Wrap-around of the sequential address.
      jumpTo(32'hFFFF_FFFC);
      check("pc_plus4 wrap", pc_plus4, 32'h0);
      cycle();
      check("pc wrap", program_counter, 32'h0);

      // Misaligned jump target is aligned and flagged stickily.
      jump_valid = 1; jump_address = 32'h0000_0102;
      cycle();
      check("misaligned target", program_counter, 32'h100);
      check("misalign set", {31'b0, misalign_err}, 32'd1);
      jump_valid = 0;
      repeat (3) cycle();
      check("misalign sticky", {31'b0, misalign_err}, 32'd1);

      // Halt at 0x30, frozen despite jump pulses, reset releases it.
      jumpTo(32'h30);
      halt = 1;
      cycle();
      halt = 0;
      check("halted set", {31'b0, halted}, 32'd1);
      check("halted fetch", {31'b0, fetch_valid}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         jump_valid = i[0]; jump_address = 32'h400;
         cycle();
      end
      jump_valid = 0;
      check("halted frozen", program_counter, 32'h30);
      doReset();
      check("reset from halt pc", program_counter, 32'h0);
      check("reset from halt", {31'b0, halted}, 32'd0);
      check("reset clears misalign", {31'b0, misalign_err}, 32'd0);
      cycle();
      check("run after halt reset", program_counter, 32'h4);

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         reset        = ($urandom_range(0, 79) == 0);
         halt         = ($urandom_range(0, 39) == 0);
         jump_valid   = ($urandom_range(0, 7) == 0);
         branch_valid = ($urandom_range(0, 7) == 0);
         stall        = ($urandom_range(0, 3) == 0);
         jump_address = $urandom;
         if ($urandom_range(0, 5) != 0) jump_address[1:0] = 2'b00;
         imm = 16'($urandom);
         branch_offset = {{14{imm[15]}}, imm, 2'b00};
         if ($urandom_range(0, 9) == 0) branch_offset[0] = 1'b1;
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
